fp_writeback_scheduler: RTL
===========================

Name: fp_writeback_scheduler

Overview:
- Controls the 32-entry float register file.
- Keeps a per-register busy scoreboard so issue stalls on RAW and WAW hazards against in-flight FP results.
- Shares the register file's single write port between the FP execution unit and the FP load unit using round-robin arbitration.
- Sits between the issue stage, the two writeback sources, and the register file's regWrite/writeRegister/writeData inputs.

Parameters:
- NUM_REGS, 32, number of float registers tracked.
- ADDR_W, 5, register address width.
- DATA_W, 32, FP data width; the register file write bus is 2*DATA_W.

Ports:
- clk  in  1  system clock; all state updates on the posedge.
- reset  in  1  asynchronous, active-high reset.
- iss_valid  in  1  the issue stage presents an FP instruction.
- iss_rs1  in  ADDR_W  source register 1.
- iss_rs2  in  ADDR_W  source register 2.
- iss_rd  in  ADDR_W  destination register.
- iss_writes  in  1  the instruction writes iss_rd.
- iss_stall  out  1  combinational; the instruction must not issue this cycle.
- fpu_wb_valid  in  1  FP unit result pending.
- fpu_wb_rd  in  ADDR_W  FP unit destination register.
- fpu_wb_data  in  DATA_W  FP unit result.
- fpu_wb_ready  out  1  combinational grant to the FP unit.
- ld_wb_valid  in  1  load result pending.
- ld_wb_rd  in  ADDR_W  load destination register.
- ld_wb_data  in  DATA_W  load data.
- ld_wb_ready  out  1  combinational grant to the load unit.
- rf_regWrite  out  1  register file write enable.
- rf_writeRegister  out  ADDR_W  register file write address.
- rf_writeData  out  2*DATA_W  register file write data: result in [DATA_W-1:0], upper half zero.
- busy_vec  out  NUM_REGS  scoreboard bits; bit i set means fi has a pending write.

Behaviour:
- Reset (async, immediate): busy_vec = 0, rf_regWrite = 0, rf_writeRegister = 0, rf_writeData = 0, rr_ptr = 0 (FPU favoured). Writebacks in flight are discarded; sources re-drive after reset.
- Stall: iss_stall = iss_valid & (busy[rs1] | busy[rs2] | (iss_writes & busy[rd])).
  - busy is the registered value; there is no same-cycle bypass of clears.
  - iss_valid = 0 gives iss_stall = 0.
- Issue accept: iss_valid & !iss_stall & iss_writes sets busy[iss_rd] at the posedge.
- Arbiter (combinational grants, at most one ready per cycle):
  - Both valid: grant the source selected by rr_ptr (0 = FPU, 1 = load), then toggle rr_ptr.
  - One valid: grant it; rr_ptr then points to the other source.
  - Neither valid: no grant; rr_ptr holds.
- Handshake: a transfer occurs when valid & ready. A source that is not granted holds valid, rd and data stable until granted.
- Write stage (one register):
  - On the posedge after a grant: rf_regWrite <= 1, rf_writeRegister <= granted rd, rf_writeData <= {zeros, granted data}.
  - With no grant: rf_regWrite <= 0; address and data hold their last values.
- Busy clear: at the posedge where rf_regWrite = 1 (the edge at which the register file captures the write), busy[rf_writeRegister] <= 0.
  - The register file reads on negedge, so an instruction issued in the cycle after the clear reads the new value.
  - Latency from grant to busy clear is 2 posedges.
  - A stalled consumer issues in the cycle after the clear edge.
- Simultaneous set and clear on the same register cannot occur: the set is blocked by the WAW stall while busy. If it does occur, set wins.
- A writeback to a non-busy register is still written; busy is unchanged.
- Back-to-back grants give one register file write per cycle (full throughput).

Optional Feature:
- Macro: FP_WB_SCHED_STATS_EN.
- When defined, three extra output ports are added:
  - stat_stall_cycles [15:0]: counts cycles with iss_stall = 1.
  - stat_conflict_cycles [15:0]: counts cycles with both wb valids high.
  - stat_writes [15:0]: counts rf_regWrite pulses.
  - All counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset mid-run with busy_vec = 32'h0000_0084 and rf_regWrite = 1 → busy_vec = 0 and rf_regWrite = 0 immediately, before the next edge.
- Issue rd = 7 with iss_writes = 1 → busy_vec[7] = 1 next cycle. Then issue rs1 = 7, rs2 = 3 → iss_stall = 1. Grant FPU wb rd = 7, data 32'h4020_0000 → rf_regWrite = 1, rf_writeRegister = 7, rf_writeData = 64'h0000_0000_4020_0000 one cycle later; busy_vec[7] = 0 and iss_stall = 0 in the following cycle.
- WAW: busy[12] = 1, issue rd = 12 with rs1 = rs2 = 0 (not busy) → iss_stall = 1. Same issue with iss_writes = 0 → iss_stall = 0.
- Both wb valid for 3 cycles (FPU rd = 2, then 21; load rd = 3, then 22) from reset → grant order FPU(2), load(3), FPU(21); rf_writeRegister sequence 2, 3, 21 on consecutive cycles.
- Load-only valid for 2 cycles, then both valid → load granted twice, then FPU granted (rr_ptr points to FPU).
- With FP_WB_SCHED_STATS_EN: 5 stall cycles and 3 writes → stat_stall_cycles = 5, stat_writes = 3. Force 70000 stall cycles → stat_stall_cycles = 16'hFFFF.

Source files
------------

// File: rtl/fp_writeback_scheduler.sv
// rtl/fp_writeback_scheduler.sv - FP register busy scoreboard with round-robin writeback arbitration
// Optional statistics counters are built when FP_WB_SCHED_STATS_EN is defined.
module fp_writeback_scheduler #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  iss_valid,
   input  logic [ADDR_W-1:0]     iss_rs1,
   input  logic [ADDR_W-1:0]     iss_rs2,
   input  logic [ADDR_W-1:0]     iss_rd,
   input  logic                  iss_writes,
   output logic                  iss_stall,
   input  logic                  fpu_wb_valid,
   input  logic [ADDR_W-1:0]     fpu_wb_rd,
   input  logic [DATA_W-1:0]     fpu_wb_data,
   output logic                  fpu_wb_ready,
   input  logic                  ld_wb_valid,
   input  logic [ADDR_W-1:0]     ld_wb_rd,
   input  logic [DATA_W-1:0]     ld_wb_data,
   output logic                  ld_wb_ready,
   output logic                  rf_regWrite,
   output logic [ADDR_W-1:0]     rf_writeRegister,
   output logic [2*DATA_W-1:0]   rf_writeData,
   output logic [NUM_REGS-1:0]   busy_vec
`ifdef FP_WB_SCHED_STATS_EN
   ,
   output logic [15:0]           stat_stall_cycles,
   output logic [15:0]           stat_conflict_cycles,
   output logic [15:0]           stat_writes
`endif
);

   typedef enum logic {RR_FPU = 1'b0, RR_LD = 1'b1} rr_e;

   rr_e                 rr_q, rr_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                issue_accept;

   assign busy_vec = busy_q;

   // Hazard check uses only the registered scoreboard; clears take effect the cycle after.
   always_comb begin
      iss_stall = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] | (iss_writes & busy_q[iss_rd]));
   end

   assign issue_accept = iss_valid & ~iss_stall & iss_writes;

   always_comb begin
      fpu_wb_ready = 1'b0;
      ld_wb_ready  = 1'b0;
      rr_d         = rr_q;
      if (fpu_wb_valid && ld_wb_valid) begin
         if (rr_q == RR_FPU) begin
            fpu_wb_ready = 1'b1;
            rr_d         = RR_LD;
         end else begin
            ld_wb_ready  = 1'b1;
            rr_d         = RR_FPU;
         end
      end else if (fpu_wb_valid) begin
         fpu_wb_ready = 1'b1;
         rr_d         = RR_LD;
      end else if (ld_wb_valid) begin
         ld_wb_ready  = 1'b1;
         rr_d         = RR_FPU;
      end
   end

   // Clear first so a coincident set on the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (rf_regWrite) begin
         busy_d[rf_writeRegister] = 1'b0;
      end
      if (issue_accept) begin
         busy_d[iss_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q             <= RR_FPU;
         busy_q           <= '0;
         rf_regWrite      <= 1'b0;
         rf_writeRegister <= '0;
         rf_writeData     <= '0;
      end else begin
         rr_q        <= rr_d;
         busy_q      <= busy_d;
         rf_regWrite <= fpu_wb_ready | ld_wb_ready;
         if (fpu_wb_ready) begin
            rf_writeRegister <= fpu_wb_rd;
            rf_writeData     <= {{DATA_W{1'b0}}, fpu_wb_data};
         end else if (ld_wb_ready) begin
            rf_writeRegister <= ld_wb_rd;
            rf_writeData     <= {{DATA_W{1'b0}}, ld_wb_data};
         end
      end
   end

`ifdef FP_WB_SCHED_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_stall_cycles    <= '0;
         stat_conflict_cycles <= '0;
         stat_writes          <= '0;
      end else begin
         if (iss_stall && stat_stall_cycles != 16'hFFFF) begin
            stat_stall_cycles <= stat_stall_cycles + 16'd1;
         end
         if (fpu_wb_valid && ld_wb_valid && stat_conflict_cycles != 16'hFFFF) begin
            stat_conflict_cycles <= stat_conflict_cycles + 16'd1;
         end
         if (rf_regWrite && stat_writes != 16'hFFFF) begin
            stat_writes <= stat_writes + 16'd1;
         end
      end
   end
`endif

endmodule
